// File: rtl/alu_pkg.sv
// Shared encodings for the 4-bit ALU and the multiply/divide sequencer
// that time-shares it.
package alu_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  localparam int STEPS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_4bit.sv
// Existing combinational 4-bit ALU: ADD/SUB/AND/OR with carry-out.
// SUB is a + ~b + 1, so cout=1 means no borrow.
module alu_4bit
  import alu_pkg::*;
(
  input  logic [1:0] op,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] result,
  output logic       cout
);

  logic [4:0] sum_s;

  // Operation select
  always_comb begin
    sum_s  = 5'd0;
    result = 4'h0;
    cout   = 1'b0;
    case (op)
      ALU_ADD: begin
        sum_s  = {1'b0, a} + {1'b0, b};
        result = sum_s[3:0];
        cout   = sum_s[4];
      end
      ALU_SUB: begin
        sum_s  = {1'b0, a} + {1'b0, ~b} + 5'd1;
        result = sum_s[3:0];
        cout   = sum_s[4];
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      default: result = 4'h0;
    endcase
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle 4x4 unsigned multiply (shift-add) and restoring divide
// sequencer sharing a single alu_4bit, with valid/ready on both sides.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter bit DBZ_FAST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_valid,
  output logic       start_ready,
  input  logic       mode,
  input  logic [3:0] opa,
  input  logic [3:0] opb,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_hi,
  output logic [3:0] res_lo,
  output logic       div_by_zero,
  output logic       busy
);

  state_e     state_q, state_d;
  logic [1:0] step_q, step_d;
  logic       mode_q, mode_d;
  logic [3:0] hi_q, hi_d;    // MUL acc_hi / DIV rem
  logic [3:0] lo_q, lo_d;    // MUL acc_lo / DIV q
  logic [3:0] opr_q, opr_d;  // MUL mcand / DIV dvs
  logic       res_valid_q, res_valid_d;
  logic [3:0] res_hi_q, res_hi_d;
  logic [3:0] res_lo_q, res_lo_d;
  logic       dbz_q, dbz_d;

  logic [1:0] alu_op_s;
  logic [3:0] alu_a_s, alu_b_s, alu_res_s;
  logic       alu_cout_s;
  logic [3:0] s_s;
  logic [4:0] mul_sum_s;
  logic [3:0] mul_hi_s, mul_lo_s, div_hi_s, div_lo_s;
  logic       qbit_s;

  alu_4bit u_alu (
    .op     (alu_op_s),
    .a      (alu_a_s),
    .b      (alu_b_s),
    .result (alu_res_s),
    .cout   (alu_cout_s)
  );

  // ALU operand steering; idle value is fixed so the shared ALU is deterministic
  always_comb begin
    alu_op_s = ALU_ADD;
    alu_a_s  = 4'h0;
    alu_b_s  = 4'h0;
    s_s      = {hi_q[2:0], lo_q[3]};
    if (state_q == RUN) begin
      if (mode_q == MODE_MUL) begin
        alu_op_s = ALU_ADD;
        alu_a_s  = hi_q;
        alu_b_s  = opr_q;
      end else begin
        alu_op_s = ALU_SUB;
        alu_a_s  = s_s;
        alu_b_s  = opr_q;
      end
    end else begin
      alu_op_s = ALU_ADD;
    end
  end

  // One multiply and one divide iteration computed from the ALU result
  always_comb begin
    if (lo_q[0]) begin
      mul_sum_s = {alu_cout_s, alu_res_s};
    end else begin
      mul_sum_s = {1'b0, hi_q};
    end
    mul_hi_s = mul_sum_s[4:1];
    mul_lo_s = {mul_sum_s[0], lo_q[3:1]};
    qbit_s   = hi_q[3] | alu_cout_s;
    div_hi_s = qbit_s ? alu_res_s : s_s;
    div_lo_s = {lo_q[2:0], qbit_s};
  end

  // Sequencer next state; results are only published on the first DONE cycle
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    mode_d      = mode_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    opr_d       = opr_q;
    res_valid_d = res_valid_q;
    res_hi_d    = res_hi_q;
    res_lo_d    = res_lo_q;
    dbz_d       = dbz_q;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          mode_d = mode;
          step_d = 2'd0;
          if (mode == MODE_MUL) begin
            hi_d    = 4'h0;
            lo_d    = opb;
            opr_d   = opa;
            state_d = RUN;
          end else if (DBZ_FAST && (opb == 4'h0)) begin
            hi_d    = opa;
            lo_d    = 4'hF;
            opr_d   = opb;
            state_d = DONE;
          end else begin
            hi_d    = 4'h0;
            lo_d    = opa;
            opr_d   = opb;
            state_d = RUN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        step_d = step_q + 2'd1;
        if (mode_q == MODE_MUL) begin
          hi_d = mul_hi_s;
          lo_d = mul_lo_s;
        end else begin
          hi_d = div_hi_s;
          lo_d = div_lo_s;
        end
        if (step_q == 2'(STEPS - 1)) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (!res_valid_q) begin
          res_valid_d = 1'b1;
          res_hi_d    = hi_q;
          res_lo_d    = lo_q;
          dbz_d       = (mode_q == MODE_DIV) && (opr_q == 4'h0);
        end else if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        res_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      step_q      <= 2'd0;
      mode_q      <= MODE_MUL;
      hi_q        <= 4'h0;
      lo_q        <= 4'h0;
      opr_q       <= 4'h0;
      res_valid_q <= 1'b0;
      res_hi_q    <= 4'h0;
      res_lo_q    <= 4'h0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      mode_q      <= mode_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      opr_q       <= opr_d;
      res_valid_q <= res_valid_d;
      res_hi_q    <= res_hi_d;
      res_lo_q    <= res_lo_d;
      dbz_q       <= dbz_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign res_valid   = res_valid_q;
  assign res_hi      = res_hi_q;
  assign res_lo      = res_lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Randomised and directed bench for alu_muldiv_seq against an arithmetic
// reference model (product, quotient/remainder, divide-by-zero convention).
module tb_alu_muldiv_seq;

  logic       clk = 1'b0;
  logic       rst_n, start_valid, start_ready, mode, res_valid, res_ready, div_by_zero, busy;
  logic [3:0] opa, opb, res_hi, res_lo;
  logic       sv0, sr0, m0, rv0, rr0, dbz0, busy0;
  logic [3:0] a0, b0, rh0, rl0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  alu_muldiv_seq #(.DBZ_FAST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .mode(mode), .opa(opa), .opb(opb), .res_valid(res_valid), .res_ready(res_ready),
    .res_hi(res_hi), .res_lo(res_lo), .div_by_zero(div_by_zero), .busy(busy)
  );

  alu_muldiv_seq #(.DBZ_FAST(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv0), .start_ready(sr0),
    .mode(m0), .opa(a0), .opb(b0), .res_valid(rv0), .res_ready(rr0),
    .res_hi(rh0), .res_lo(rl0), .div_by_zero(dbz0), .busy(busy0)
  );

  // {hi, lo, div_by_zero} from plain arithmetic
  function automatic logic [8:0] model(input logic m, input logic [3:0] a, input logic [3:0] b);
    int ai, bi, p;
    ai = int'(a);
    bi = int'(b);
    if (m == 1'b0) begin
      p = ai * bi;
      return {p[7:0], 1'b0};
    end
    if (bi == 0) return {a, 4'hF, 1'b1};
    p = ((ai % bi) << 4) | (ai / bi);
    return {p[7:0], 1'b0};
  endfunction

  // Entry and exit at a falling edge with the DUT idle; res_ready stays high
  task automatic run_cmd(input logic m, input logic [3:0] a, input logic [3:0] b, input int lat);
    logic [8:0] exp_v;
    logic [1:0] exp_op;
    int n;
    exp_v = model(m, a, b);
    exp_op = m ? 2'b01 : 2'b00;
    res_ready = 1'b1;
    start_valid = 1'b1; mode = m; opa = a; opb = b;
    checks++;
    if (start_ready !== 1'b1) begin errors++; $display("FAIL start_ready_idle got %b exp 1", start_ready); end
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0; opa = 4'($urandom); opb = 4'($urandom); mode = 1'($urandom);
    n = 0;
    while (res_valid !== 1'b1 && n < 20) begin
      if (lat == 5 && n <= 3) begin
        checks++;
        if (dut.alu_op_s !== exp_op) begin errors++; $display("FAIL alu_op m=%b step=%0d got %b exp %b", m, n, dut.alu_op_s, exp_op); end
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != lat) begin errors++; $display("FAIL latency m=%b a=%h b=%h got %0d exp %0d", m, a, b, n, lat); end
    checks++;
    if ({res_hi, res_lo, div_by_zero} !== exp_v) begin
      errors++; $display("FAIL result m=%b a=%h b=%h got %h exp %h", m, a, b, {res_hi, res_lo, div_by_zero}, exp_v);
    end
    @(negedge clk);
    checks++;
    if ({res_valid, busy, start_ready, res_hi, res_lo, div_by_zero} !== {3'b001, exp_v}) begin
      errors++; $display("FAIL after_handshake got %b exp %b", {res_valid, busy, start_ready, res_hi, res_lo, div_by_zero}, {3'b001, exp_v});
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start_valid = 1'b0; mode = 1'b0; opa = 4'h0; opb = 4'h0; res_ready = 1'b1;
    sv0 = 1'b0; m0 = 1'b0; a0 = 4'h0; b0 = 4'h0; rr0 = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({res_valid, busy, res_hi, res_lo, div_by_zero, start_ready} !== 12'b0000_0000_0001) begin
      errors++; $display("FAIL reset_state got %b exp 000000000001", {res_valid, busy, res_hi, res_lo, div_by_zero, start_ready});
    end
  endtask

  task automatic test_directed;
    logic [12:0] vec [10];
    vec = '{ {1'b0, 4'hF, 4'hF}, {1'b0, 4'h7, 4'h0}, {1'b0, 4'h0, 4'h9}, {1'b0, 4'h5, 4'h3},
             {1'b0, 4'h8, 4'h2}, {1'b1, 4'hD, 4'h3}, {1'b1, 4'hF, 4'h1}, {1'b1, 4'hF, 4'h9},
             {1'b1, 4'h3, 4'h7}, {1'b1, 4'h9, 4'h0} };
    for (int i = 0; i < 10; i++) begin
      run_cmd(vec[i][8], vec[i][7:4], vec[i][3:0], (vec[i][8] && vec[i][3:0] == 4'h0) ? 1 : 5);
    end
  endtask

  task automatic test_random;
    logic m;
    logic [3:0] a, b;
    for (int i = 0; i < 30; i++) begin
      m = 1'($urandom); a = 4'($urandom); b = 4'($urandom);
      run_cmd(m, a, b, (m && b == 4'h0) ? 1 : 5);
    end
  endtask

  // Divide by zero on the slow-path instance runs the full sequence
  task automatic test_dbz_slow;
    logic [3:0] dvd [2];
    int n;
    dvd[0] = 4'h9;
    dvd[1] = 4'($urandom);
    for (int i = 0; i < 2; i++) begin
      sv0 = 1'b1; m0 = 1'b1; a0 = dvd[i]; b0 = 4'h0; rr0 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      sv0 = 1'b0; a0 = 4'($urandom);
      n = 0;
      while (rv0 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (n != 5) begin errors++; $display("FAIL dbz_slow_latency got %0d exp 5", n); end
      checks++;
      if ({rh0, rl0, dbz0} !== model(1'b1, dvd[i], 4'h0)) begin
        errors++; $display("FAIL dbz_slow_result got %h exp %h", {rh0, rl0, dbz0}, model(1'b1, dvd[i], 4'h0));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure;
    logic [3:0] a, b, na, nb;
    logic [8:0] exp_v, exp_n;
    int n;
    a = 4'($urandom); b = 4'($urandom); na = 4'($urandom); nb = 4'($urandom_range(1, 15));
    exp_v = model(1'b0, a, b);
    exp_n = model(1'b1, na, nb);
    res_ready = 1'b0;
    start_valid = 1'b1; mode = 1'b0; opa = a; opb = b;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    n = 0;
    while (res_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (n != 5) begin errors++; $display("FAIL bp_latency got %0d exp 5", n); end
    for (int i = 0; i < 3; i++) begin
      start_valid = 1'b1; mode = 1'b1; opa = na; opb = nb;
      @(negedge clk);
      checks++;
      if ({res_valid, start_ready, res_hi, res_lo, div_by_zero} !== {2'b10, exp_v}) begin
        errors++; $display("FAIL bp_hold cyc=%0d got %b exp %b", i, {res_valid, start_ready, res_hi, res_lo, div_by_zero}, {2'b10, exp_v});
      end
    end
    res_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({res_valid, start_ready} !== 2'b01) begin errors++; $display("FAIL bp_release got %b exp 01", {res_valid, start_ready}); end
    @(negedge clk);
    start_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL bp_b2b_accept got %b exp 1", busy); end
    n = 0;
    while (res_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (n != 5 || {res_hi, res_lo, div_by_zero} !== exp_n) begin
      errors++; $display("FAIL bp_next got lat=%0d %h exp lat=5 %h", n, {res_hi, res_lo, div_by_zero}, exp_n);
    end
    @(negedge clk);
  endtask

  task automatic test_mid_reset;
    start_valid = 1'b1; mode = 1'b0; opa = 4'hB; opb = 4'hD; res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({res_valid, busy, res_hi, res_lo, div_by_zero, start_ready} !== 12'b0000_0000_0001) begin
      errors++; $display("FAIL mid_reset got %b exp 000000000001", {res_valid, busy, res_hi, res_lo, div_by_zero, start_ready});
    end
    run_cmd(1'b0, 4'h6, 4'h6, 5);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_dbz_slow();
    test_backpressure();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
